// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: issues reads to a 1-cycle synchronous instruction memory and buffers
// the returned instructions with their PCs in a small FIFO, presented through a valid/ready handshake.
module fetch_queue_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_en,
  output logic [15:0]              imem_addr,
  input  logic [15:0]              imem_data,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     inst_valid,
  output logic [15:0]              inst_out,
  output logic [15:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [15:0]   fetch_pc_r;
  logic          inflight_r;
  logic [15:0]   inflight_pc_r;
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [15:0]   inst_mem_r [DEPTH];
  logic [15:0]   pc_mem_r   [DEPTH];

  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   demand_s;

  // Handshake, issue decision and head presentation
  always_comb begin
    pop_s      = 1'b0;
    push_s     = 1'b0;
    issue_s    = 1'b0;
    demand_s   = {(CW + 1){1'b0}};
    inst_valid = (count_r != {CW{1'b0}});
    inst_out   = NOP_INST;
    inst_pc    = 16'h0000;

    pop_s  = inst_valid & inst_ready;
    push_s = inflight_r & ~redirect;
    // Slots already committed (queued + returning) minus the one leaving this cycle
    demand_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    issue_s  = rst & ~redirect & (demand_s < DEPTH_W);

    if (inst_valid) begin
      inst_out = inst_mem_r[head_r];
      inst_pc  = pc_mem_r[head_r];
    end else begin
      inst_out = NOP_INST;
      inst_pc  = 16'h0000;
    end
  end

  assign imem_en   = issue_s;
  assign imem_addr = fetch_pc_r;
  assign occupancy = count_r;

  // Fetch PC, in-flight tracking and queue pointers; redirect squashes everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 16'h0000;
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc;
      inflight_r    <= 1'b0;
      head_r        <= {PW{1'b0}};
      tail_r        <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + 16'h0001;
      end
      if (push_s) begin
        tail_r <= tail_r + PW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PW'(1);
      end
      count_r <= count_r + {{(CW - 1){1'b0}}, push_s} - {{(CW - 1){1'b0}}, pop_s};
    end
  end

  // Queue storage; contents are only observed through count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[tail_r] <= imem_data;
      pc_mem_r[tail_r]   <= inflight_pc_r;
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized self-checking bench for fetch_queue_stage against a queue-based model of the
// fetch/issue/flush rules; instruction memory returns mem[a] = a + 16'h0100.
module tb_fetch_queue_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic [1:0]  occupancy;

  fetch_queue_stage #(.DEPTH(DEPTH), .RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_ready(inst_ready), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] inst; logic [15:0] pc; } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fetch;
  bit          m_busy;
  logic [15:0] m_busy_pc;
  bit          prev_en;
  logic [15:0] prev_addr;
  int          n_checks;
  int          n_fail;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch   = 16'h0000;
    m_busy    = 0;
    m_busy_pc = 16'h0000;
    prev_en   = 0;
  endtask

  // One clock cycle: drive at the negedge, check after settling, advance the model at the posedge
  task automatic step(input bit rd, input logic [15:0] rpc, input bit rdy);
    bit   e_valid, e_pop, e_en;
    int   committed;
    ent_t e;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    imem_data   = prev_en ? mem_word(prev_addr) : 16'($urandom);
    #1;
    e_valid   = (mq.size() != 0);
    e_pop     = e_valid && rdy;
    committed = mq.size() + int'(m_busy) - int'(e_pop);
    e_en      = !rd && (committed < DEPTH);
    chk("inst_valid", {15'd0, inst_valid}, {15'd0, e_valid});
    chk("inst_out", inst_out, e_valid ? mq[0].inst : 16'h0000);
    chk("inst_pc", inst_pc, e_valid ? mq[0].pc : 16'h0000);
    chk("occupancy", {14'd0, occupancy}, 16'(mq.size()));
    chk("imem_en", {15'd0, imem_en}, {15'd0, e_en});
    chk("imem_addr", imem_addr, m_fetch);
    prev_en   = imem_en;
    prev_addr = imem_addr;
    @(posedge clk);
    if (rd) begin
      mq.delete();
      m_busy  = 0;
      m_fetch = rpc;
    end else begin
      if (e_pop) void'(mq.pop_front());
      if (m_busy) begin
        e.inst = mem_word(m_busy_pc);
        e.pc   = m_busy_pc;
        mq.push_back(e);
      end
      m_busy = e_en;
      if (e_en) begin
        m_busy_pc = m_fetch;
        m_fetch   = m_fetch + 16'h0001;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {15'd0, inst_valid}, 16'h0000);
    chk({tag, "_out"}, inst_out, 16'h0000);
    chk({tag, "_pc"}, inst_pc, 16'h0000);
    chk({tag, "_occ"}, {14'd0, occupancy}, 16'h0000);
    chk({tag, "_en"}, {15'd0, imem_en}, 16'h0000);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    inst_ready  = 1'b0;
    imem_data   = 16'h0000;
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming with ready high, then back-pressure, then drain
    repeat (10) step(1'b0, 16'h0000, 1'b1);
    repeat (6)  step(1'b0, 16'h0000, 1'b0);
    repeat (6)  step(1'b0, 16'h0000, 1'b1);
    // Fill while a read is in flight, then redirect
    step(1'b0, 16'h0000, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'h0040, 1'b0);
    repeat (5) step(1'b0, 16'h0000, 1'b1);
    // Redirect with pop, and back-to-back redirects
    step(1'b1, 16'h0010, 1'b1);
    step(1'b1, 16'h0020, 1'b1);
    repeat (5) step(1'b0, 16'h0000, 1'b1);
    // PC wrap-around
    step(1'b1, 16'hFFFE, 1'b1);
    repeat (7) step(1'b0, 16'h0000, 1'b1);

    // Asynchronous reset mid-stream with a full queue
    repeat (4) step(1'b0, 16'h0000, 1'b0);
    chk("pre_reset_occ", {14'd0, occupancy}, 16'd2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) step(1'b0, 16'h0000, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0,
           ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch stage directly upstream of the datapath.
- Drives the synchronous instruction memory address and buffers returned 16-bit instructions, with their PCs, in a small FIFO.
- Presents instructions to decode/datapath through a valid/ready handshake.
- Accepts redirects (taken branch, jump, for-loop, return via RR) that flush all buffered and in-flight instructions.

Parameters:
- DEPTH, 2, queue entries; power of two, 2..8.
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INST, 16'h0000, value driven on inst_out when the queue is empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_en  out  1  read enable to instruction memory; combinational.
- imem_addr  out  16  read address; equals fetch_pc; combinational.
- imem_data  in  16  instruction; valid the cycle after an enabled read (fixed 1-cycle latency, memory never stalls).
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address.
- inst_valid  out  1  queue head is valid.
- inst_out  out  16  head instruction, or NOP_INST when empty.
- inst_pc  out  16  PC of head instruction, or 0 when empty.
- inst_ready  in  1  consumer accepts the head this cycle.
- occupancy  out  log2(DEPTH)+1  entries currently in the queue.

Behaviour:
- State:
  - fetch_pc (16 b).
  - inflight flag plus inflight_pc (16 b).
  - circular queue: head/tail pointers and count, DEPTH x {inst, pc}.
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; inflight=0; count=0; pointers=0.
  - Outputs: inst_valid=0, inst_out=NOP_INST, inst_pc=0, occupancy=0, imem_en=0.
  - imem_en is forced 0 while rst=0.
  - Reset mid-operation discards everything; no partial state survives.
- pop = inst_valid & inst_ready.
- Issue rule: imem_en = rst & ~redirect & (count + inflight - pop < DEPTH).
  - Arithmetic is unsigned, one bit wider than count.
  - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^16; 16'hFFFF wraps to 16'h0000).
  - Otherwise inflight<=0.
- Response:
  - If inflight=1 in a cycle with no redirect, {imem_data, inflight_pc} is written at tail at the next edge.
  - The issue rule guarantees no overflow.
- Push and pop in the same cycle: both happen; count is unchanged; legal when full.
- Latency: an issue in cycle T becomes the queue head visible in cycle T+2 if the queue was empty. Outputs are registered/queue-read with no bypass.
- Throughput: 1 instruction/cycle sustained while inst_ready=1.
- Ordering: FIFO; inst_pc values out are strictly consecutive between redirects.
- Redirect (highest priority), in cycle T:
  - No issue in T; any response returning in T is discarded.
  - Next edge: count=0, pointers=0, inflight=0, fetch_pc=redirect_pc.
  - pop in the same cycle is ignored; the consumer must treat redirect as a squash.
  - First target instruction appears at inst_valid in cycle T+3.
- Back-to-back redirects: the last one wins; each re-clears.
- inst_out and inst_pc are stable while inst_valid=1 and inst_ready=0.
- occupancy mirrors count.

Test Plan:
- Release reset, inst_ready=1, imem returns mem[a]=a+16'h100 -> imem_addr 0,1,2,… one per cycle; first inst_valid 2 cycles after first issue with inst_out=16'h0100, inst_pc=0; then one instruction per cycle.
- Same with inst_ready=0 -> exactly DEPTH (2) issues, occupancy=2, imem_en=0 thereafter. Raise inst_ready -> PCs 0,1,2… delivered in order with no loss or duplicate.
- Redirect to 16'h0040 while queue full and read inflight -> next cycle occupancy=0, inst_valid=0; imem_addr=16'h0040 one cycle later; inst_pc=16'h0040 appears 3 cycles after redirect; the stale response is never output.
- Redirect asserted together with pop, and on two consecutive cycles (16'h0010 then 16'h0020) -> only the 16'h0020 stream is delivered; first PC out is 16'h0020.
- redirect_pc=16'hFFFE, ready=1 -> inst_pc sequence FFFE, FFFF, 0000, 0001.
- Assert rst=0 asynchronously mid-stream with occupancy=2 -> outputs go to reset values immediately, not at the clock edge; after release, fetch restarts at RESET_PC.
